// File: rtl/nbit_regfile.sv
`default_nettype none
// ============================================================================
// Module      : nbit_regfile
// Description : Parameterised register file, one write port and two
//               registered read ports with optional zero entry and bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module nbit_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] WAddr,
    input  logic [DATA_WIDTH-1:0] WData,
    input  logic [ADDR_WIDTH-1:0] RAddrA,
    input  logic [ADDR_WIDTH-1:0] RAddrB,
    input  logic                  ReadEn,
    output logic [DATA_WIDTH-1:0] QA,
    output logic [DATA_WIDTH-1:0] QB
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  w_wr_eff;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    // Writes to entry 0 are dropped when it is hardwired to zero.
    assign w_wr_eff = Write && !((ZERO_REG != 0) && (WAddr == '0));

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic w_we;
            assign w_we = w_wr_eff && (WAddr == ADDR_WIDTH'(i));

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_mem[i] <= '0;
                end else if (w_we) begin
                    r_mem[i] <= WData;
                end
            end
        end
    endgenerate

    // Read selection: zero entry overrides bypass, which overrides storage.
    always_comb begin
        w_rd_a = r_mem[RAddrA];
        w_rd_b = r_mem[RAddrB];
        if ((BYPASS != 0) && w_wr_eff && (WAddr == RAddrA)) begin
            w_rd_a = WData;
        end
        if ((BYPASS != 0) && w_wr_eff && (WAddr == RAddrB)) begin
            w_rd_b = WData;
        end
        if ((ZERO_REG != 0) && (RAddrA == '0)) begin
            w_rd_a = '0;
        end
        if ((ZERO_REG != 0) && (RAddrB == '0)) begin
            w_rd_b = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            QA <= '0;
            QB <= '0;
        end else if (ReadEn) begin
            QA <= w_rd_a;
            QB <= w_rd_b;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nbit_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_nbit_regfile
// Description : Directed self-checking bench; a BYPASS=1 and a BYPASS=0
//               instance share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nbit_regfile;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Write = 1'b0;
    logic [4:0]  WAddr = '0;
    logic [31:0] WData = '0;
    logic [4:0]  RAddrA = '0;
    logic [4:0]  RAddrB = '0;
    logic        ReadEn = 1'b0;
    logic [31:0] QA, QB, QA_nb, QB_nb;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    nbit_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .Clk(Clk), .Reset(Reset), .Write(Write), .WAddr(WAddr), .WData(WData),
        .RAddrA(RAddrA), .RAddrB(RAddrB), .ReadEn(ReadEn), .QA(QA), .QB(QB)
    );

    nbit_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .Write(Write), .WAddr(WAddr), .WData(WData),
        .RAddrA(RAddrA), .RAddrB(RAddrB), .ReadEn(ReadEn), .QA(QA_nb), .QB(QB_nb)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        Reset = 1'b0; Write = 1'b0; ReadEn = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        idle();
        checks++; if (QA !== 32'h0) begin errors++; $display("FAIL reset_qa got=%h exp=%h", QA, 32'h0); end
        checks++; if (QB !== 32'h0) begin errors++; $display("FAIL reset_qb got=%h exp=%h", QB, 32'h0); end
        ReadEn = 1'b1; RAddrA = 5'd7; RAddrB = 5'd31;
        tick();
        idle();
        checks++; if (QA !== 32'h0) begin errors++; $display("FAIL reset_read_a7 got=%h exp=%h", QA, 32'h0); end
        checks++; if (QB !== 32'h0) begin errors++; $display("FAIL reset_read_b31 got=%h exp=%h", QB, 32'h0); end
    endtask

    task automatic test_write_read();
        Write = 1'b1; WAddr = 5'd5; WData = 32'hDEADBEEF;
        tick();
        idle();
        checks++; if (QA !== 32'h0) begin errors++; $display("FAIL wr_no_readen got=%h exp=%h", QA, 32'h0); end
        ReadEn = 1'b1; RAddrA = 5'd5; RAddrB = 5'd5;
        tick();
        idle();
        checks++; if (QA !== 32'hDEADBEEF) begin errors++; $display("FAIL read_a5 got=%h exp=%h", QA, 32'hDEADBEEF); end
        checks++; if (QB !== 32'hDEADBEEF) begin errors++; $display("FAIL read_b5_same got=%h exp=%h", QB, 32'hDEADBEEF); end
        // Top two addresses must be distinct entries.
        Write = 1'b1; WAddr = 5'd31; WData = 32'h0000_1F1F;
        tick();
        WAddr = 5'd30; WData = 32'h0000_1E1E;
        tick();
        idle();
        ReadEn = 1'b1; RAddrA = 5'd31; RAddrB = 5'd30;
        tick();
        idle();
        checks++; if (QA !== 32'h0000_1F1F) begin errors++; $display("FAIL read_a31 got=%h exp=%h", QA, 32'h0000_1F1F); end
        checks++; if (QB !== 32'h0000_1E1E) begin errors++; $display("FAIL read_b30 got=%h exp=%h", QB, 32'h0000_1E1E); end
    endtask

    task automatic test_zero_reg();
        Write = 1'b1; WAddr = 5'd0; WData = 32'h12345678;
        tick();
        idle();
        ReadEn = 1'b1; RAddrA = 5'd0; RAddrB = 5'd0;
        tick();
        idle();
        checks++; if (QA !== 32'h0) begin errors++; $display("FAIL zero_qa got=%h exp=%h", QA, 32'h0); end
        checks++; if (QB !== 32'h0) begin errors++; $display("FAIL zero_qb got=%h exp=%h", QB, 32'h0); end
        // Write to 0 concurrent with a read of 0 must not be bypassed.
        Write = 1'b1; WAddr = 5'd0; WData = 32'hFFFFFFFF; ReadEn = 1'b1;
        tick();
        idle();
        checks++; if (QA !== 32'h0) begin errors++; $display("FAIL zero_bypass_qa got=%h exp=%h", QA, 32'h0); end
    endtask

    task automatic test_bypass();
        Write = 1'b1; WAddr = 5'd9; WData = 32'h1;
        tick();
        idle();
        Write = 1'b1; WAddr = 5'd9; WData = 32'hA5A5A5A5;
        ReadEn = 1'b1; RAddrA = 5'd5; RAddrB = 5'd9;
        tick();
        idle();
        checks++; if (QB !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_on_qb got=%h exp=%h", QB, 32'hA5A5A5A5); end
        checks++; if (QB_nb !== 32'h1) begin errors++; $display("FAIL bypass_off_qb got=%h exp=%h", QB_nb, 32'h1); end
        checks++; if (QA !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_other_qa got=%h exp=%h", QA, 32'hDEADBEEF); end
        ReadEn = 1'b1;
        tick();
        idle();
        checks++; if (QB_nb !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_off_next got=%h exp=%h", QB_nb, 32'hA5A5A5A5); end
    endtask

    task automatic test_hold();
        // QA currently shows entry 5 = DEADBEEF.
        Write = 1'b1; WAddr = 5'd5; WData = 32'hFFFF0000; RAddrA = 5'd9;
        tick();
        idle();
        checks++; if (QA !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_qa got=%h exp=%h", QA, 32'hDEADBEEF); end
        tick();
        checks++; if (QA !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_qa2 got=%h exp=%h", QA, 32'hDEADBEEF); end
        ReadEn = 1'b1; RAddrA = 5'd5;
        tick();
        idle();
        checks++; if (QA !== 32'hFFFF0000) begin errors++; $display("FAIL hold_reload got=%h exp=%h", QA, 32'hFFFF0000); end
    endtask

    task automatic test_reset_priority();
        Reset = 1'b1; Write = 1'b1; WAddr = 5'd3; WData = 32'h55;
        ReadEn = 1'b1; RAddrA = 5'd3; RAddrB = 5'd3;
        tick();
        idle();
        checks++; if (QA !== 32'h0) begin errors++; $display("FAIL rstpri_qa got=%h exp=%h", QA, 32'h0); end
        ReadEn = 1'b1; RAddrA = 5'd3; RAddrB = 5'd5;
        tick();
        idle();
        checks++; if (QA !== 32'h0) begin errors++; $display("FAIL rstpri_read3 got=%h exp=%h", QA, 32'h0); end
        checks++; if (QB !== 32'h0) begin errors++; $display("FAIL rst_cleared5 got=%h exp=%h", QB, 32'h0); end
    endtask

    task automatic test_sync_reset();
        Write = 1'b1; WAddr = 5'd3; WData = 32'h77;
        tick();
        idle();
        ReadEn = 1'b1; RAddrA = 5'd3;
        tick();
        idle();
        // Reset pulse entirely between edges must be ignored.
        #2 Reset = 1'b1;
        #3 Reset = 1'b0;
        tick();
        checks++; if (QA !== 32'h77) begin errors++; $display("FAIL sync_rst_q got=%h exp=%h", QA, 32'h77); end
        ReadEn = 1'b1; RAddrA = 5'd3;
        tick();
        idle();
        checks++; if (QA !== 32'h77) begin errors++; $display("FAIL sync_rst_mem got=%h exp=%h", QA, 32'h77); end
    endtask

    task automatic test_back_to_back();
        Write = 1'b1; WAddr = 5'd12; WData = 32'h0C0C0C0C;
        tick();
        WAddr = 5'd13; WData = 32'h0D0D0D0D;
        ReadEn = 1'b1; RAddrA = 5'd12; RAddrB = 5'd13;
        tick();
        idle();
        checks++; if (QA !== 32'h0C0C0C0C) begin errors++; $display("FAIL b2b_qa got=%h exp=%h", QA, 32'h0C0C0C0C); end
        checks++; if (QB !== 32'h0D0D0D0D) begin errors++; $display("FAIL b2b_qb got=%h exp=%h", QB, 32'h0D0D0D0D); end
        checks++; if (QB_nb !== 32'h0) begin errors++; $display("FAIL b2b_qb_nb got=%h exp=%h", QB_nb, 32'h0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_hold();
        test_reset_priority();
        test_sync_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
